// File: rtl/zeus_axis_pkg.sv
// Shared types and tkeep helpers for the AXI-Stream FIFO read-side blocks.
// Widths are fixed at package maxima; modules zero-extend into them.
package zeus_axis_pkg;

    localparam int KEEP_W_MAX = 256;
    localparam int LEN_W_MAX  = 32;

    typedef struct packed {
        logic [LEN_W_MAX-1:0] bytes;
        logic                 err;
    } len_rec_t;

    function automatic logic [15:0] keep_popcount(input logic [KEEP_W_MAX-1:0] tkeep);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < KEEP_W_MAX; i++) begin
            n = n + {15'd0, tkeep[i]};
        end
        return n;
    endfunction

    // True only for non-zero, LSB-aligned runs of ones (2**k-1).
    function automatic logic keep_is_contig(input logic [KEEP_W_MAX-1:0] tkeep);
        logic [KEEP_W_MAX-1:0] plus_one;
        plus_one = tkeep + {{(KEEP_W_MAX-1){1'b0}}, 1'b1};
        return (tkeep != '0) && ((tkeep & plus_one) == '0);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register FIFO with registered ready; a full beat per clock at steady state.
module axis_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              push;
    logic              pop;

    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign m_valid = (count != 2'd0);
    assign m_data  = mem[rd_ptr];

    always_comb begin
        count_next = count + {1'b0, push} - {1'b0, pop};
    end

    // Ready is the registered next-state "not full", so it never depends on m_ready in-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            s_ready <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_next;
            s_ready <= (count_next != 2'd2);
        end
    end

endmodule

// File: rtl/axis_pkt_len_reader.sv
// Forwards FIFO packets through a skid buffer while measuring byte length and tkeep sanity,
// publishing one {length, error} record per packet plus wrapping packet/error counters.
module axis_pkt_len_reader
    import zeus_axis_pkg::*;
#(
    parameter int TDATA_WIDTH = 512,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                     s_aclk,
    input  logic                     s_aresetn,
    input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [LEN_WIDTH-1:0]     m_len_bytes,
    output logic                     m_len_err,
    output logic                     m_len_valid,
    input  logic                     m_len_ready,
    output logic [CNT_WIDTH-1:0]     pkt_count,
    output logic [CNT_WIDTH-1:0]     err_count
);

    localparam int KW     = TDATA_WIDTH / 8;
    localparam int SKID_W = TDATA_WIDTH + KW + 1;
    localparam int SUM_W  = LEN_WIDTH + 17;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    logic                  skid_ready;
    logic                  lq_ready;
    logic                  accept;
    logic [SKID_W-1:0]     skid_out;

    logic [0:0]            state;
    logic [LEN_WIDTH-1:0]  acc;
    logic                  err_acc;

    logic [KEEP_W_MAX-1:0] keep_ext;
    logic [15:0]           beat_bytes;
    logic [LEN_WIDTH-1:0]  acc_base;
    logic                  err_base;
    logic [SUM_W-1:0]      sum;
    logic                  sat_hit;
    logic [LEN_WIDTH-1:0]  len_sat;
    logic                  beat_err;
    logic                  pkt_err;

    len_rec_t              lq_mem [2];
    len_rec_t              new_rec;
    len_rec_t              lq_head;
    logic                  lq_wr;
    logic                  lq_rd;
    logic [1:0]            lq_count;
    logic [1:0]            lq_count_next;
    logic                  lq_push;
    logic                  lq_pop;

    assign s_axis_tready = skid_ready && lq_ready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    axis_skid_buffer #(
        .DATA_W (SKID_W)
    ) u_skid (
        .clk     (s_aclk),
        .rst_n   (s_aresetn),
        .s_data  ({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
        .s_valid (s_axis_tvalid && lq_ready),
        .s_ready (skid_ready),
        .m_data  (skid_out),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = skid_out;

    always_comb begin
        keep_ext         = '0;
        keep_ext[KW-1:0] = s_axis_tkeep;
    end

    // An exact 2**LEN_WIDTH-1 total is flagged too: it cannot be told apart from a clamped one.
    always_comb begin
        beat_bytes = keep_popcount(keep_ext);
        acc_base   = (state == ST_IN_PKT) ? acc : '0;
        err_base   = (state == ST_IN_PKT) ? err_acc : 1'b0;
        sum        = {{17{1'b0}}, acc_base} + {{(SUM_W-16){1'b0}}, beat_bytes};
        sat_hit    = (sum >= {{17{1'b0}}, LEN_MAX});
        len_sat    = sat_hit ? LEN_MAX : sum[LEN_WIDTH-1:0];
        beat_err   = s_axis_tlast ? !keep_is_contig(keep_ext) : (s_axis_tkeep != '1);
        pkt_err    = err_base || beat_err || sat_hit;
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            state   <= ST_IDLE;
            acc     <= '0;
            err_acc <= 1'b0;
        end else if (accept) begin
            if (s_axis_tlast) begin
                state   <= ST_IDLE;
                acc     <= '0;
                err_acc <= 1'b0;
            end else begin
                state   <= ST_IN_PKT;
                acc     <= len_sat;
                err_acc <= pkt_err;
            end
        end
    end

    assign lq_push     = accept && s_axis_tlast;
    assign lq_pop      = m_len_valid && m_len_ready;
    assign lq_head     = lq_mem[lq_rd];
    assign m_len_valid = (lq_count != 2'd0);
    assign m_len_bytes = lq_head.bytes[LEN_WIDTH-1:0];
    assign m_len_err   = lq_head.err;

    always_comb begin
        new_rec                       = '0;
        new_rec.bytes[LEN_WIDTH-1:0]  = len_sat;
        new_rec.err                   = pkt_err;
        lq_count_next                 = lq_count + {1'b0, lq_push} - {1'b0, lq_pop};
    end

    generate
        if (LEN_WIDTH < LEN_W_MAX) begin : g_head_pad
            logic head_pad_unused;
            assign head_pad_unused = |lq_head.bytes[LEN_W_MAX-1:LEN_WIDTH];
        end
    endgenerate

    // When full and popping, the write slot equals the slot being drained, so overwrite is safe.
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            lq_mem[0] <= '0;
            lq_mem[1] <= '0;
            lq_wr     <= 1'b0;
            lq_rd     <= 1'b0;
            lq_count  <= 2'd0;
            lq_ready  <= 1'b0;
        end else begin
            if (lq_push) begin
                lq_mem[lq_wr] <= new_rec;
                lq_wr         <= ~lq_wr;
            end
            if (lq_pop) begin
                lq_rd <= ~lq_rd;
            end
            lq_count <= lq_count_next;
            lq_ready <= (lq_count_next != 2'd2);
        end
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            pkt_count <= '0;
            err_count <= '0;
        end else if (lq_push) begin
            pkt_count <= pkt_count + CNT_WIDTH'(1);
            if (pkt_err) begin
                err_count <= err_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_len_reader.sv
// Scoreboard bench for axis_pkt_len_reader: default instance plus a LEN_WIDTH=8 instance.
module tb_axis_pkt_len_reader;

    localparam int DW = 512;
    localparam int KW = 64;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [15:0] bytes;
        logic        err;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast, s_tvalid, s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast, m_tvalid, m_tready;
    logic [15:0]   m_len_bytes;
    logic          m_len_err, m_len_valid, m_len_ready;
    logic [31:0]   pkt_count, err_count;

    logic [DW-1:0] n_tdata;
    logic [KW-1:0] n_tkeep;
    logic          n_tlast, n_tvalid, n_tready;
    logic [DW-1:0] n_m_tdata;
    logic [KW-1:0] n_m_tkeep;
    logic          n_m_tlast, n_m_tvalid, n_m_tready;
    logic [7:0]    n_len_bytes;
    logic          n_len_err, n_len_valid, n_len_ready;
    logic [31:0]   n_pkt_count, n_err_count;

    logic m_rdy_base;
    logic toggle_en = 1'b0;
    logic tog = 1'b1;
    assign m_tready = toggle_en ? tog : m_rdy_base;

    always @(posedge clk) begin
        #1;
        tog = toggle_en ? ~tog : 1'b1;
    end

    axis_pkt_len_reader dut (
        .s_aclk(clk), .s_aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_len_bytes(m_len_bytes), .m_len_err(m_len_err),
        .m_len_valid(m_len_valid), .m_len_ready(m_len_ready),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    axis_pkt_len_reader #(.TDATA_WIDTH(512), .LEN_WIDTH(8), .CNT_WIDTH(32)) dut8 (
        .s_aclk(clk), .s_aresetn(rst_n),
        .s_axis_tdata(n_tdata), .s_axis_tkeep(n_tkeep), .s_axis_tlast(n_tlast),
        .s_axis_tvalid(n_tvalid), .s_axis_tready(n_tready),
        .m_axis_tdata(n_m_tdata), .m_axis_tkeep(n_m_tkeep), .m_axis_tlast(n_m_tlast),
        .m_axis_tvalid(n_m_tvalid), .m_axis_tready(n_m_tready),
        .m_len_bytes(n_len_bytes), .m_len_err(n_len_err),
        .m_len_valid(n_len_valid), .m_len_ready(n_len_ready),
        .pkt_count(n_pkt_count), .err_count(n_err_count)
    );

    // Monitor: records every output handshake; sampled on the falling edge.
    beat_t obs_beat [128];
    int    obs_beat_n = 0;
    rec_t  obs_rec [32];
    int    obs_rec_n = 0;
    rec_t  obs_rec8 [8];
    int    obs_rec8_n = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_tvalid && m_tready && obs_beat_n < 128) begin
                obs_beat[obs_beat_n] = '{data: m_tdata, keep: m_tkeep, last: m_tlast};
                obs_beat_n++;
            end
            if (m_len_valid && m_len_ready && obs_rec_n < 32) begin
                obs_rec[obs_rec_n] = '{bytes: m_len_bytes, err: m_len_err};
                obs_rec_n++;
            end
            if (n_len_valid && n_len_ready && obs_rec8_n < 8) begin
                obs_rec8[obs_rec8_n] = '{bytes: {8'd0, n_len_bytes}, err: n_len_err};
                obs_rec8_n++;
            end
        end
    end

    int    tests = 0;
    int    fails = 0;
    beat_t exp_beat [$];
    rec_t  exp_rec [$];
    rec_t  exp_rec8 [$];
    int    beat_rd = 0;
    int    rec_rd = 0;
    int    rec8_rd = 0;
    int    m_acc = 0;
    bit    m_err = 1'b0;
    int    m_pkts = 0;
    int    m_errs = 0;
    int    n_pkts = 0;
    int    n_errs = 0;

    function automatic int popc(input logic [KW-1:0] k);
        int n = 0;
        for (int i = 0; i < KW; i++) n += int'(k[i]);
        return n;
    endfunction

    function automatic bit contig(input logic [KW-1:0] k);
        bit seen_zero = 1'b0;
        if (k == '0) return 1'b0;
        for (int i = 0; i < KW; i++) begin
            if (!k[i]) seen_zero = 1'b1;
            else if (seen_zero) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one beat into the wide (narrow=0) or LEN_WIDTH=8 (narrow=1) instance and models it.
    task automatic applyStimulus(input bit narrow, input logic [DW-1:0] d,
                                 input logic [KW-1:0] k, input logic l);
        int waited = 0;
        int sum;
        int lim;
        bit e;
        lim = narrow ? 255 : 65535;
        if (narrow) begin
            n_tdata = d; n_tkeep = k; n_tlast = l; n_tvalid = 1'b1;
        end else begin
            s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        end
        while (!(narrow ? n_tready : s_tready) && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 200) begin
            checkOutput("accept_timeout", DW'(waited), DW'(0));
            s_tvalid = 1'b0;
            n_tvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        n_tvalid = 1'b0;
        if (!narrow) exp_beat.push_back('{data: d, keep: k, last: l});
        sum = m_acc + popc(k);
        e   = m_err;
        if (l) e |= !contig(k);
        else   e |= (k != '1);
        if (sum >= lim) begin
            sum = lim;
            e   = 1'b1;
        end
        if (l) begin
            if (narrow) begin
                exp_rec8.push_back('{bytes: 16'(sum), err: e});
                n_pkts++;
                if (e) n_errs++;
            end else begin
                exp_rec.push_back('{bytes: 16'(sum), err: e});
                m_pkts++;
                if (e) m_errs++;
            end
            m_acc = 0;
            m_err = 1'b0;
        end else begin
            m_acc = sum;
            m_err = e;
        end
    endtask

    task automatic drainChecks();
        int    waited = 0;
        beat_t eb, ob;
        rec_t  er, orr;
        while ((obs_beat_n - beat_rd < exp_beat.size() || obs_rec_n - rec_rd < exp_rec.size() ||
                obs_rec8_n - rec8_rd < exp_rec8.size()) && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 500) checkOutput("drain_timeout", DW'(waited), DW'(0));
        while (exp_beat.size() > 0 && beat_rd < obs_beat_n) begin
            eb = exp_beat.pop_front();
            ob = obs_beat[beat_rd];
            beat_rd++;
            checkOutput("beat_data", ob.data, eb.data);
            checkOutput("beat_keep", DW'(ob.keep), DW'(eb.keep));
            checkOutput("beat_last", DW'(ob.last), DW'(eb.last));
        end
        while (exp_rec.size() > 0 && rec_rd < obs_rec_n) begin
            er  = exp_rec.pop_front();
            orr = obs_rec[rec_rd];
            rec_rd++;
            checkOutput("len_bytes", DW'(orr.bytes), DW'(er.bytes));
            checkOutput("len_err", DW'(orr.err), DW'(er.err));
        end
        while (exp_rec8.size() > 0 && rec8_rd < obs_rec8_n) begin
            er  = exp_rec8.pop_front();
            orr = obs_rec8[rec8_rd];
            rec8_rd++;
            checkOutput("len8_bytes", DW'(orr.bytes), DW'(er.bytes));
            checkOutput("len8_err", DW'(orr.err), DW'(er.err));
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("extra_beats", DW'(obs_beat_n - beat_rd), DW'(0));
        checkOutput("extra_recs", DW'(obs_rec_n - rec_rd), DW'(0));
        checkOutput("pkt_count", DW'(pkt_count), DW'(m_pkts));
        checkOutput("err_count", DW'(err_count), DW'(m_errs));
    endtask

    initial begin
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        n_tdata = '0; n_tkeep = '0; n_tlast = 1'b0; n_tvalid = 1'b0;
        m_rdy_base = 1'b1; m_len_ready = 1'b1; n_len_ready = 1'b1; n_m_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_s_tready", DW'(s_tready), DW'(0));
        checkOutput("rst_m_tvalid", DW'(m_tvalid), DW'(0));
        checkOutput("rst_m_tdata", m_tdata, DW'(0));
        checkOutput("rst_len_valid", DW'(m_len_valid), DW'(0));
        checkOutput("rst_pkt_count", DW'(pkt_count), DW'(0));
        checkOutput("rst_n_tready", DW'(n_tready), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("tready_before_edge", DW'(s_tready), DW'(0));
        @(posedge clk); #1;
        checkOutput("tready_after_release", DW'(s_tready), DW'(1));

        // 3-beat packet: 64 + 64 + 4 bytes
        applyStimulus(0, rnd_data(), '1, 1'b0);
        applyStimulus(0, rnd_data(), '1, 1'b0);
        applyStimulus(0, rnd_data(), 64'h000F, 1'b1);
        drainChecks();

        // Two single-beat packets with the length sideband stalled
        m_len_ready = 1'b0;
        applyStimulus(0, rnd_data(), 64'h1, 1'b1);
        applyStimulus(0, rnd_data(), 64'h1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("lq_full_valid", DW'(m_len_valid), DW'(1));
        checkOutput("lq_full_backpressure", DW'(s_tready), DW'(0));
        checkOutput("lq_head_bytes", DW'(m_len_bytes), DW'(1));
        m_len_ready = 1'b1;
        drainChecks();

        // Fill the skid, then check s_tready ignores m_axis_tready within the cycle
        m_rdy_base = 1'b0;
        applyStimulus(0, rnd_data(), '1, 1'b0);
        applyStimulus(0, rnd_data(), '1, 1'b0);
        @(negedge clk); #1;
        checkOutput("skid_full_tready", DW'(s_tready), DW'(0));
        m_rdy_base = 1'b1;
        #1;
        checkOutput("tready_comb_path", DW'(s_tready), DW'(0));
        m_rdy_base = 1'b0;
        @(posedge clk); #1;
        m_rdy_base = 1'b1;
        applyStimulus(0, rnd_data(), '1, 1'b1);
        drainChecks();

        // Continuous input with m_axis_tready toggling every cycle
        toggle_en = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(0, rnd_data(), '1, (i == 5));
        drainChecks();
        toggle_en = 1'b0;

        // tkeep violations still forward data and flag the record
        applyStimulus(0, rnd_data(), 64'hFFFE, 1'b0);
        applyStimulus(0, rnd_data(), 64'h0005, 1'b1);
        drainChecks();

        // Length saturation on the LEN_WIDTH=8 instance
        for (int i = 0; i < 5; i++) applyStimulus(1, rnd_data(), '1, (i == 4));
        drainChecks();
        checkOutput("n_pkt_count", DW'(n_pkt_count), DW'(n_pkts));
        checkOutput("n_err_count", DW'(n_err_count), DW'(n_errs));

        // Reset in the middle of a packet
        applyStimulus(0, rnd_data(), '1, 1'b0);
        drainChecks();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_s_tready", DW'(s_tready), DW'(0));
        checkOutput("midrst_m_tvalid", DW'(m_tvalid), DW'(0));
        checkOutput("midrst_m_tdata", m_tdata, DW'(0));
        checkOutput("midrst_len_valid", DW'(m_len_valid), DW'(0));
        checkOutput("midrst_pkt_count", DW'(pkt_count), DW'(0));
        checkOutput("midrst_err_count", DW'(err_count), DW'(0));
        m_acc = 0; m_err = 1'b0; m_pkts = 0; m_errs = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, rnd_data(), 64'hFF, 1'b1);
        drainChecks();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
